// File: rtl/song_mem_ctrl.sv
// rtl/song_mem_ctrl.sv - song record/playback controller for the external sample memory
// Writes ticks into a 16-slot sample store or plays them back, tracking recorded length per slot.
module song_mem_ctrl #(
    parameter int SLOT_W = 15,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_song,
    input  logic              pause_song,
    input  logic [3:0]        song_choice,
    input  logic              record_mode,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] rec_sample,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] play_sample,
    output logic              play_valid,
    output logic              song_done,
    output logic              busy
);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        PLAY_RUN,
        PLAY_RD,
        REC_RUN,
        REC_WR,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         slot_q, slot_d;
    logic [SLOT_W-1:0]  off_q, off_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  ps_q, ps_d;
    logic               pv_q, pv_d;
    logic [SLOT_W:0]    len_q [16];
    logic               len_we;
    logic [SLOT_W:0]    len_wval;
    logic [SLOT_W:0]    off_nxt;
    logic [SLOT_W-1:0]  off_inc;
    logic               tick_ok;

    assign off_nxt = {1'b0, off_q} + 1'b1;
    // Offset saturates at the last sample of a slot instead of rolling over.
    assign off_inc = (off_q == '1) ? off_q : off_q + 1'b1;
    assign tick_ok = sample_tick && !pause_song;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        ps_d     = ps_q;
        pv_d     = 1'b0;
        len_we   = 1'b0;
        len_wval = '0;
        if (start_song) begin
            slot_d = song_choice;
            off_d  = '0;
            cnt_d  = '0;
            if (record_mode) begin
                state_d = REC_RUN;
                len_we  = 1'b1;
            end else begin
                state_d = PLAY_RUN;
            end
        end else begin
            case (state_q)
                PLAY_RUN: begin
                    if (len_q[slot_q] == '0) begin
                        state_d = DONE;
                    end else if (tick_ok) begin
                        state_d = PLAY_RD;
                        cnt_d   = CNT_W'(RD_LAT);
                    end
                end
                PLAY_RD: begin
                    if (cnt_q == CNT_W'(1)) begin
                        ps_d    = mem_rdata;
                        pv_d    = 1'b1;
                        off_d   = off_inc;
                        state_d = (off_nxt == len_q[slot_q]) ? DONE : PLAY_RUN;
                    end
                    cnt_d = cnt_q - 1'b1;
                end
                REC_RUN: begin
                    if (tick_ok) begin
                        state_d = REC_WR;
                        wdata_d = rec_sample;
                    end
                end
                REC_WR: begin
                    len_we   = 1'b1;
                    len_wval = off_nxt;
                    off_d    = off_inc;
                    state_d  = (off_q == '1) ? DONE : REC_RUN;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            ps_q    <= '0;
            pv_q    <= 1'b0;
            for (int i = 0; i < 16; i++) len_q[i] <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            ps_q    <= ps_d;
            pv_q    <= pv_d;
            if (len_we) len_q[slot_d] <= len_wval;
        end
    end

    assign mem_addr    = {slot_q, off_q};
    assign mem_we      = (state_q == REC_WR);
    assign mem_wdata   = wdata_q;
    assign play_sample = ps_q;
    assign play_valid  = pv_q;
    assign song_done   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_song_mem_ctrl.sv
// tb/tb_song_mem_ctrl.sv - self-checking bench for song_mem_ctrl with a behavioural session model
module tb_song_mem_ctrl;
    localparam int SLOT_W = 2;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << SLOT_W;

    logic              clk, reset, start_song, pause_song, record_mode, sample_tick;
    logic [3:0]        song_choice;
    logic [DATA_W-1:0] rec_sample, mem_rdata, mem_wdata, play_sample;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we, play_valid, song_done, busy;

    song_mem_ctrl #(.SLOT_W(SLOT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start_song(start_song), .pause_song(pause_song),
        .song_choice(song_choice), .record_mode(record_mode), .sample_tick(sample_tick),
        .rec_sample(rec_sample), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .play_sample(play_sample), .play_valid(play_valid),
        .song_done(song_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // External memory with an RD_LAT-deep read pipeline.
    logic [DATA_W-1:0] bmem [1 << ADDR_W];
    logic [DATA_W-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        if (mem_we) bmem[mem_addr] <= mem_wdata;
        rpipe[0] <= bmem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Session model: session 0 none, 1 playback, 2 record.
    int          session, slot, offset, rd_left;
    bit          wr_now, done_now, exp_pv;
    logic [7:0]  exp_ps, exp_wdata;
    int          mlen [16];
    logic [7:0]  mmem [1 << ADDR_W];

    task automatic model_clear();
        session = 0; slot = 0; offset = 0; rd_left = 0;
        wr_now = 0; done_now = 0; exp_pv = 0; exp_ps = 0; exp_wdata = 0;
        for (int i = 0; i < 16; i++) mlen[i] = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            if (wr_now) mmem[slot*DEPTH + offset] = exp_wdata;
            exp_pv = 0;
            if (start_song) begin
                slot = int'(song_choice); offset = 0; rd_left = 0; wr_now = 0; done_now = 0;
                if (record_mode) begin session = 2; mlen[slot] = 0; end
                else session = 1;
            end else if (done_now) begin
                done_now = 0;
            end else if (session == 1) begin
                if (rd_left > 0) begin
                    rd_left--;
                    if (rd_left == 0) begin
                        exp_ps = mmem[slot*DEPTH + offset];
                        exp_pv = 1;
                        if (offset + 1 == mlen[slot]) begin done_now = 1; session = 0; end
                        if (offset < DEPTH - 1) offset++;
                    end
                end else if (mlen[slot] == 0) begin
                    done_now = 1; session = 0;
                end else if (sample_tick && !pause_song) begin
                    rd_left = RD_LAT;
                end
            end else if (session == 2) begin
                if (wr_now) begin
                    wr_now = 0;
                    mlen[slot] = offset + 1;
                    if (offset == DEPTH - 1) begin done_now = 1; session = 0; end
                    else offset++;
                end else if (sample_tick && !pause_song) begin
                    wr_now = 1; exp_wdata = rec_sample;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) model_clear();
        check("mem_addr", mem_addr, slot*DEPTH + offset);
        check("mem_we", mem_we, wr_now);
        check("mem_wdata", mem_wdata, exp_wdata);
        check("play_sample", play_sample, exp_ps);
        check("play_valid", play_valid, exp_pv);
        check("song_done", song_done, done_now);
        check("busy", busy, (session != 0) || done_now);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start(input int s, input logic rec);
        start_song = 1; song_choice = 4'(s); record_mode = rec;
        @(posedge clk); #1;
        start_song = 0;
    endtask

    task automatic tick(input logic [7:0] d);
        sample_tick = 1; rec_sample = d;
        @(posedge clk); #1;
        sample_tick = 0;
    endtask

    logic [7:0] vals [3];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin bmem[i] = '0; mmem[i] = '0; end
        for (int i = 0; i < RD_LAT; i++) rpipe[i] = '0;
        model_clear();
        clk = 0; reset = 0; start_song = 0; pause_song = 0; song_choice = 0;
        record_mode = 0; sample_tick = 0; rec_sample = 0;
        idle(2);
        check("rst_busy", busy, 0);
        check("rst_addr", mem_addr, 0);
        reset = 1;
        idle(1);
        tick(8'hAA);
        check("notstart_we", mem_we, 0);
        idle(3);
        check("notstart_pv", play_valid, 0);

        // Record then play back three samples in slot 2.
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        start(2, 1);
        for (int i = 0; i < 3; i++) begin
            tick(vals[i]);
            check("rec_we", mem_we, 1);
            check("rec_addr", mem_addr, 6'h08 + i);
            check("rec_wdata", mem_wdata, vals[i]);
            idle(RD_LAT + 1);
        end
        start(2, 0);
        for (int i = 0; i < 3; i++) begin
            tick(8'h00);
            idle(RD_LAT - 1);
            check("play_early_pv", play_valid, 0);
            idle(1);
            check("play_pv", play_valid, 1);
            check("play_sample", play_sample, vals[i]);
            check("play_done", song_done, (i == 2) ? 1 : 0);
            idle(1);
        end
        check("play_end_busy", busy, 0);

        // Reset while a read is in flight.
        start(2, 0);
        tick(8'h00);
        reset = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_pv", play_valid, 0);
        idle(3);
        reset = 1;
        idle(1);

        // Empty slot playback after reset.
        start(7, 0);
        check("empty_s1_done", song_done, 0);
        idle(1);
        check("empty_s2_done", song_done, 1);
        idle(1);
        check("empty_s3_done", song_done, 0);
        check("empty_s3_busy", busy, 0);
        start(7, 0);
        check("empty_restart_done", song_done, 0);
        idle(3);

        // Paused ticks are ignored; released tick writes offset 0.
        start(1, 1);
        pause_song = 1;
        repeat (5) begin tick(8'h66); idle(RD_LAT + 1); end
        check("pause_addr", mem_addr, 6'h04);
        pause_song = 0;
        tick(8'h5A);
        check("pause_we", mem_we, 1);
        check("pause_waddr", mem_addr, 6'h04);
        idle(RD_LAT + 1);
        start(1, 0);
        tick(8'h00);
        idle(RD_LAT);
        check("pause_play", play_sample, 8'h5A);
        check("pause_play_done", song_done, 1);
        idle(2);

        // Fill slot 3 completely, then play it back.
        start(3, 1);
        for (int i = 0; i < DEPTH; i++) begin tick(8'hC0 + 8'(i)); idle(1); end
        check("full_done", song_done, 1);
        check("full_nowrap", mem_addr, 6'h0F);
        idle(2);
        tick(8'hEE);
        check("full_no5th", mem_we, 0);
        idle(2);
        start(3, 0);
        for (int i = 0; i < DEPTH; i++) begin
            tick(8'h00);
            idle(RD_LAT);
            check("full_play", play_sample, 8'hC0 + 8'(i));
            idle(1);
        end

        // Start during a write cycle restarts in the new slot.
        start(5, 1);
        tick(8'h77);
        start(6, 1);
        check("restart_addr", mem_addr, 6'h18);
        check("restart_we", mem_we, 0);
        tick(8'h99);
        check("restart_waddr", mem_addr, 6'h18);
        idle(RD_LAT + 1);

        // Randomized sessions.
        for (int s = 0; s < 60; s++) begin
            int nt;
            start($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            nt = $urandom_range(1, 7);
            for (int k = 0; k < nt; k++) begin
                pause_song = ($urandom_range(0, 4) == 0);
                tick(8'($urandom));
                if ($urandom_range(0, 7) == 0) start($urandom_range(0, 3), 1'($urandom_range(0, 1)));
                else idle($urandom_range(RD_LAT + 1, RD_LAT + 4));
            end
            pause_song = 0;
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin reset = 0; idle(1); reset = 1; end
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
